em4100_scheduler: RTL and testbench

Round-robin transmit scheduler for the EM4100 encoder. It holds a small table of 40-bit tag IDs. For each valid slot in turn it drives the encoder's `data` and `tx` inputs for a programmed number of complete frames, then inserts an idle gap before the next slot. It sits between the host/config logic and the encoder, so several emulated tags can share one encoder and one antenna.

---
 rtl/em4100_pkg.sv | 14 +
 rtl/rr_pick.sv | 31 +++
 rtl/em4100_scheduler.sv | 141 ++++++++++++++
 tb/tb_em4100_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/em4100_pkg.sv
// Shared types and constants for the EM4100 transmit path.
package em4100_pkg;

  localparam int unsigned EM4100_FRAME_CYCLES = 120;
  localparam int unsigned EM4100_ID_W         = 40;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP
  } sched_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid slot after last_i, wrapping.
module rr_pick #(
  parameter int unsigned SLOTS = 4
) (
  input  logic [SLOTS-1:0]         valid_i,
  input  logic [$clog2(SLOTS)-1:0] last_i,
  output logic [$clog2(SLOTS)-1:0] sel_o,
  output logic                     any_o
);

  localparam int unsigned IDX_W = $clog2(SLOTS);

  logic [IDX_W-1:0] idx;
  logic             found;

  // SLOTS is a power of two, so truncating last_i+k to IDX_W bits is the modulo.
  always_comb begin
    sel_o = '0;
    any_o = |valid_i;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= SLOTS; k++) begin
      idx = last_i + IDX_W'(k);
      if (!found && valid_i[idx]) begin
        sel_o = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/em4100_scheduler.sv
// Round-robin transmit scheduler: sends each valid table ID for a set number
// of complete frames, with an idle gap between slots.
module em4100_scheduler
  import em4100_pkg::*;
#(
  parameter int unsigned SLOTS        = 4,
  parameter int unsigned FRAME_CYCLES = EM4100_FRAME_CYCLES,
  parameter int unsigned REPEAT_W     = 8,
  parameter int unsigned GAP_W        = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     wr_en,
  input  logic [$clog2(SLOTS)-1:0] wr_slot,
  input  logic [EM4100_ID_W-1:0]   wr_id,
  input  logic                     wr_valid,
  input  logic [REPEAT_W-1:0]      repeat_cnt,
  input  logic [GAP_W-1:0]         gap_cnt,
  output logic                     tx_out,
  output logic [EM4100_ID_W-1:0]   data_out,
  output logic [$clog2(SLOTS)-1:0] cur_slot,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int unsigned IDX_W  = $clog2(SLOTS);
  localparam int unsigned FCNT_W = $clog2(FRAME_CYCLES);

  sched_state_e state_q, state_d;

  logic [SLOTS-1:0]       valid_q;
  logic [EM4100_ID_W-1:0] id_q [SLOTS];
  logic [EM4100_ID_W-1:0] data_q;
  logic [IDX_W-1:0]       cur_q, last_q;
  logic [REPEAT_W-1:0]    rep_q, sent_q, rep_eff;
  logic [FCNT_W-1:0]      fcnt_q;
  logic [GAP_W-1:0]       gap_q;

  logic [IDX_W-1:0] sel;
  logic             any;
  logic             start_ok, frame_end, last_frame, do_load, gap_load;

  rr_pick #(.SLOTS(SLOTS)) u_pick (
    .valid_i (valid_q),
    .last_i  (last_q),
    .sel_o   (sel),
    .any_o   (any)
  );

  always_comb begin
    state_d    = state_q;
    do_load    = 1'b0;
    gap_load   = 1'b0;
    start_ok   = enable && any;
    rep_eff    = (rep_q == '0) ? REPEAT_W'(1) : rep_q;
    frame_end  = (state_q == ST_SEND) && (fcnt_q == FCNT_W'(FRAME_CYCLES - 1));
    last_frame = ((sent_q + REPEAT_W'(1)) == rep_eff) || !enable;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_LOAD;
          do_load = 1'b1;
        end
      end
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: begin
        // A zero gap skips GAP entirely, so the exit decision is made here.
        if (frame_end && last_frame) begin
          if (gap_cnt != '0) begin
            state_d  = ST_GAP;
            gap_load = 1'b1;
          end else if (start_ok) begin
            state_d = ST_LOAD;
            do_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(1)) begin
          if (start_ok) begin
            state_d = ST_LOAD;
            do_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= '0;
      for (int unsigned k = 0; k < SLOTS; k++) id_q[k] <= '0;
      data_q  <= '0;
      cur_q   <= '0;
      last_q  <= IDX_W'(SLOTS - 1);
      rep_q   <= '0;
      sent_q  <= '0;
      fcnt_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      if (wr_en) begin
        valid_q[wr_slot] <= wr_valid;
        id_q[wr_slot]    <= wr_id;
      end
      if (do_load) begin
        data_q <= id_q[sel];
        cur_q  <= sel;
        last_q <= sel;
        rep_q  <= repeat_cnt;
      end
      if (state_q == ST_LOAD) begin
        fcnt_q <= '0;
        sent_q <= '0;
      end else if (state_q == ST_SEND) begin
        if (frame_end) begin
          fcnt_q <= '0;
          sent_q <= sent_q + REPEAT_W'(1);
        end else begin
          fcnt_q <= fcnt_q + FCNT_W'(1);
        end
      end
      if (gap_load) gap_q <= gap_cnt;
      else if (state_q == ST_GAP) gap_q <= gap_q - GAP_W'(1);
    end
  end

  assign tx_out     = (state_q == ST_SEND);
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_end;
  assign data_out   = data_q;
  assign cur_slot   = cur_q;

endmodule

// File: tb/tb_em4100_scheduler.sv
// Bench for em4100_scheduler: burst-level reference model (slot order, burst
// length, gap length) checked against observed tx_out runs.
module tb_em4100_scheduler;

  localparam int FC = 120;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_slot = '0;
  logic [39:0] wr_id = '0;
  logic        wr_valid = 1'b0;
  logic [7:0]  repeat_cnt = '0;
  logic [7:0]  gap_cnt = '0;
  logic        tx_out, busy, frame_done;
  logic [39:0] data_out;
  logic [1:0]  cur_slot;

  em4100_scheduler #(.SLOTS(4), .FRAME_CYCLES(FC), .REPEAT_W(8), .GAP_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_slot    (wr_slot),
    .wr_id      (wr_id),
    .wr_valid   (wr_valid),
    .repeat_cnt (repeat_cnt),
    .gap_cnt    (gap_cnt),
    .tx_out     (tx_out),
    .data_out   (data_out),
    .cur_slot   (cur_slot),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: table contents, last-served slot, pending config.
  bit          m_valid [4];
  logic [39:0] m_id [4];
  int          m_last = 3;
  int          m_rep = 0;
  int          m_gap = 0;

  int          exp_slot, exp_hi, exp_fd, wticks;
  logic [39:0] exp_id;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int eff(input int r);
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int m_pick();
    for (int i = 1; i <= 4; i++) begin
      if (m_valid[(m_last + i) % 4]) return (m_last + i) % 4;
    end
    return -1;
  endfunction

  function automatic int m_count_valid_except(input int s);
    int c = 0;
    for (int i = 0; i < 4; i++) if (i != s && m_valid[i]) c++;
    return c;
  endfunction

  task automatic wr(input int s, input logic [39:0] id, input bit v);
    wr_en    = 1'b1;
    wr_slot  = 2'(s);
    wr_id    = id;
    wr_valid = v;
    tick();
    wr_en = 1'b0;
    wticks++;
    m_valid[s] = v;
    m_id[s]    = id;
  endtask

  task automatic set_cfg(input int r, input int g);
    repeat_cnt = 8'(r);
    gap_cnt    = 8'(g);
    m_rep      = r;
    m_gap      = g;
  endtask

  task automatic count_high(input int offset, output int n, output int fd,
                            output int first_fd, output int last_fd,
                            output logic [39:0] last_data);
    n = 0; fd = 0; first_fd = -1; last_fd = -1; last_data = '0;
    while (tx_out === 1'b1 && n < 800) begin
      if (frame_done === 1'b1) begin
        fd++;
        if (first_fd < 0) first_fd = offset + n;
        last_fd = offset + n;
      end
      last_data = data_out;
      n++;
      tick();
    end
  endtask

  task automatic count_low(input int bound, output int n);
    n = 0;
    while (tx_out !== 1'b1 && n < bound) begin
      n++;
      tick();
    end
  endtask

  // Called on the first SEND cycle of a burst.
  task automatic start_burst();
    exp_slot = m_pick();
    exp_id   = (exp_slot >= 0) ? m_id[exp_slot] : '0;
    exp_hi   = eff(m_rep) * FC;
    exp_fd   = eff(m_rep);
    chk("burst_tx", tx_out, 1);
    chk("burst_slot", cur_slot, exp_slot);
    chk("burst_id", data_out, exp_id);
    if (exp_slot >= 0) m_last = exp_slot;
    wticks = 0;
  endtask

  task automatic end_burst();
    int rem, fd, ffd, lfd, lo;
    logic [39:0] ld;
    count_high(wticks, rem, fd, ffd, lfd, ld);
    chk("burst_high_len", wticks + rem, exp_hi);
    chk("burst_frames", fd, exp_fd);
    chk("first_frame_done", ffd, FC - 1);
    chk("last_frame_done", lfd, exp_hi - 1);
    chk("burst_id_stable", ld, exp_id);
    count_low(300, lo);
    chk("gap_low_len", lo, m_gap + 1);
  endtask

  initial begin
    int lo, rem, fd, ffd, lfd, s;
    bit v;
    logic [39:0] ld;
    logic [63:0] r64;

    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_id[i]    = '0;
    end

    tick(); tick(); tick();
    chk("rst_tx", tx_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_slot", cur_slot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fd", frame_done, 0);
    rst_n = 1'b1;
    tick();

    // Single slot, start latency, two frames per burst.
    wr(0, 40'h12_3456_789A, 1'b1);
    set_cfg(2, 5);
    enable = 1'b1;
    tick();
    chk("load_busy", busy, 1);
    chk("load_tx", tx_out, 0);
    chk("load_slot", cur_slot, 0);
    chk("load_data", data_out, 40'h12_3456_789A);
    tick();
    start_burst();
    end_burst();

    // Configure slots 2 and 3; slot 1 stays invalid and must be skipped.
    start_burst();
    wr(2, 40'hAA_0000_0002, 1'b1);
    wr(3, 40'hBB_0000_0003, 1'b1);
    set_cfg(1, 3);
    end_burst();
    start_burst(); end_burst();
    start_burst(); end_burst();

    // Live write to the slot being sent.
    start_burst();
    wr(0, 40'hC0_FFEE_0000, 1'b1);
    set_cfg(0, 0);
    end_burst();
    start_burst(); end_burst();
    start_burst(); end_burst();
    start_burst(); end_burst();

    for (int b = 0; b < 8; b++) begin
      start_burst();
      if ($urandom_range(0, 1) == 1) begin
        s   = int'($urandom_range(0, 3));
        v   = bit'($urandom_range(0, 1));
        r64 = {$urandom(), $urandom()};
        if (!v && m_count_valid_except(s) == 0) v = 1'b1;
        wr(s, r64[39:0], v);
      end
      set_cfg(int'($urandom_range(0, 2)), int'($urandom_range(0, 6)));
      end_burst();
    end

    // Early stop during frame 1 of 3.
    start_burst();
    set_cfg(3, 4);
    end_burst();
    start_burst();
    repeat (50) tick();
    enable = 1'b0;
    count_high(50, rem, fd, ffd, lfd, ld);
    chk("stop_high_len", 50 + rem, FC);
    chk("stop_frames", fd, 1);
    chk("stop_gap_busy", busy, 1);
    repeat (4) tick();
    chk("stop_idle_busy", busy, 0);
    count_low(200, lo);
    chk("stop_no_tx", lo, 200);
    chk("stop_busy_after", busy, 0);

    // Restart latency, then reset mid-SEND.
    enable = 1'b1;
    count_low(10, lo);
    chk("restart_latency", lo, 2);
    start_burst();
    repeat (30) tick();
    rst_n = 1'b0;
    tick();
    chk("mrst_tx", tx_out, 0);
    chk("mrst_data", data_out, 0);
    chk("mrst_slot", cur_slot, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_fd", frame_done, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_id[i]    = '0;
    end
    m_last = 3;
    count_low(40, lo);
    chk("mrst_stays_idle", lo, 40);
    chk("mrst_idle_busy", busy, 0);

    enable = 1'b0;
    wr(3, 40'hDD_0000_0003, 1'b1);
    wr(0, 40'hEE_0000_0000, 1'b1);
    set_cfg(1, 2);
    enable = 1'b1;
    count_low(10, lo);
    chk("post_rst_latency", lo, 2);
    start_burst();
    end_burst();
    start_burst();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
